// File: rtl/pc_sequencer.sv
// Multi-phase program-counter sequencer: the PC advances once every PHASES
// cycles of a single clock. It supports stall, halt, branch and a retired-instruction count.
module pc_sequencer #(
    parameter int PC_WIDTH     = 16,
    parameter int PHASES       = 8,
    parameter int RESET_VECTOR = 0,
    parameter int PC_INC       = 1,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                       clock,
    input  logic                       clr,
    input  logic                       stall,
    input  logic                       halt,
    input  logic                       branch_en,
    input  logic [PC_WIDTH-1:0]        branch_target,
    output logic [PC_WIDTH-1:0]        pc,
    output logic [$clog2(PHASES)-1:0]  phase,
    output logic                       commit,
    output logic                       pc_wrap,
    output logic [1:0]                 state,
    output logic [CNT_WIDTH-1:0]       retired
);

    localparam int PH_W = $clog2(PHASES);

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_STALL = 2'd1;
    localparam logic [1:0] ST_HALT  = 2'd2;

    localparam logic [PH_W-1:0]     PH_LAST = PH_W'(PHASES - 1);
    localparam logic [PC_WIDTH-1:0] PC_RST  = PC_WIDTH'(RESET_VECTOR);
    localparam logic [PC_WIDTH:0]   INC_EXT = (PC_WIDTH + 1)'(PC_INC);

    logic [PC_WIDTH-1:0]  r_pc;
    logic [PH_W-1:0]      r_phase;
    logic                 r_wrap;
    logic [1:0]           r_state;
    logic [CNT_WIDTH-1:0] r_retired;

    logic                 w_adv;
    logic                 w_commit;
    logic [PC_WIDTH:0]    w_sum;

    // Handshake-free block: commit is a pure function of the current state and inputs,
    // and it is asserted for the single cycle whose rising edge retires the instruction.
    assign w_adv    = clr && (r_state == ST_RUN) && !stall;
    assign w_commit = w_adv && (r_phase == PH_LAST);
    assign w_sum    = {1'b0, r_pc} + INC_EXT;

    always_ff @(posedge clock) begin
        if (!clr) begin
            r_pc      <= PC_RST;
            r_phase   <= '0;
            r_wrap    <= 1'b0;
            r_state   <= ST_RUN;
            r_retired <= '0;
        end else begin
            r_wrap <= 1'b0;
            case (r_state)
                ST_RUN: begin
                    if (stall) begin
                        r_state <= ST_STALL;
                    end else if (w_commit) begin
                        r_phase   <= '0;
                        r_retired <= r_retired + 1'b1;
                        if (halt) begin
                            r_state <= ST_HALT;
                        end else if (branch_en) begin
                            r_pc <= branch_target;
                        end else begin
                            r_pc   <= w_sum[PC_WIDTH-1:0];
                            r_wrap <= w_sum[PC_WIDTH];
                        end
                    end else begin
                        r_phase <= r_phase + 1'b1;
                    end
                end
                ST_STALL: begin
                    if (!stall) begin
                        r_state <= ST_RUN;
                    end
                end
                default: begin
                    // HALT (and the unused encoding) is left only through clr.
                    r_state <= r_state;
                end
            endcase
        end
    end

    assign pc      = r_pc;
    assign phase   = r_phase;
    assign commit  = w_commit;
    assign pc_wrap = r_wrap;
    assign state   = r_state;
    assign retired = r_retired;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios, then randomized traffic checked
// cycle by cycle against an instruction-level reference model.
module tb_pc_sequencer;

  localparam int PC_WIDTH  = 16;
  localparam int PHASES    = 8;
  localparam int CNT_WIDTH = 16;
  localparam int PC_MOD    = 1 << PC_WIDTH;
  localparam int CNT_MOD   = 1 << CNT_WIDTH;

  logic                  clock;
  logic                  clr;
  logic                  stall;
  logic                  halt;
  logic                  branch_en;
  logic [PC_WIDTH-1:0]   branch_target;
  logic [PC_WIDTH-1:0]   pc;
  logic [2:0]            phase;
  logic                  commit;
  logic                  pc_wrap;
  logic [1:0]            state;
  logic [CNT_WIDTH-1:0]  retired;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model: plain integers, modes use the published output encoding
  int m_pc, m_phase, m_mode, m_ret, m_wrap;
  bit chk_en = 0;
  bit obs_commit;
  logic [PC_WIDTH-1:0] exp_q[$];

  pc_sequencer #(
    .PC_WIDTH(PC_WIDTH), .PHASES(PHASES), .RESET_VECTOR(0), .PC_INC(1), .CNT_WIDTH(CNT_WIDTH)
  ) dut (
    .clock(clock), .clr(clr), .stall(stall), .halt(halt), .branch_en(branch_en),
    .branch_target(branch_target), .pc(pc), .phase(phase), .commit(commit),
    .pc_wrap(pc_wrap), .state(state), .retired(retired)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit model_commit(input int c, input int s);
    return (c != 0) && (m_mode == 0) && (s == 0) && (m_phase == PHASES - 1);
  endfunction

  task automatic model_edge(input int c, input int s, input int h, input int b, input int t);
    int sum;
    bit go;
    if (c == 0) begin
      m_pc = 0; m_phase = 0; m_mode = 0; m_ret = 0; m_wrap = 0;
    end else begin
      m_wrap = 0;
      go = (m_mode == 0) && (s == 0);
      if (m_mode == 0 && s != 0) m_mode = 1;
      else if (m_mode == 1 && s == 0) m_mode = 0;
      if (go) begin
        if (m_phase == PHASES - 1) begin
          m_phase = 0;
          m_ret = (m_ret + 1) % CNT_MOD;
          if (h != 0) m_mode = 2;
          else if (b != 0) m_pc = t % PC_MOD;
          else begin
            sum = m_pc + 1;
            m_wrap = (sum >= PC_MOD) ? 1 : 0;
            m_pc = sum % PC_MOD;
          end
        end else begin
          m_phase = m_phase + 1;
        end
      end
    end
  endtask

  // driver: one clock cycle with the given inputs, scoreboard check before the edge
  task automatic step(input int c, input int s, input int h, input int b, input int t);
    bit mc;
    @(negedge clock);
    clr = (c != 0); stall = (s != 0); halt = (h != 0); branch_en = (b != 0);
    branch_target = PC_WIDTH'(t);
    #1;
    mc = model_commit(c, s);
    obs_commit = commit;
    if (chk_en) begin
      check("pc", 32'(pc), 32'(m_pc));
      check("phase", 32'(phase), 32'(m_phase));
      check("state", 32'(state), 32'(m_mode));
      check("retired", 32'(retired), 32'(m_ret));
      check("pc_wrap", 32'(pc_wrap), 32'(m_wrap));
      check("commit", 32'(commit), 32'(mc));
      if (exp_q.size() > 0) check("commit_pc", 32'(pc), 32'(exp_q.pop_front()));
    end
    @(posedge clock);
    model_edge(c, s, h, b, t);
    if (mc) exp_q.push_back(PC_WIDTH'(m_pc));
  endtask

  initial begin
    int n;
    int k;
    bit found;
    int seen[3];
    clr = 1'b0; stall = 1'b0; halt = 1'b0; branch_en = 1'b0; branch_target = '0;

    // reset, including one edge with every other control asserted
    step(0, 0, 0, 0, 0);
    chk_en = 1;
    step(0, 1, 1, 1, 16'hABCD);
    #1;
    check("rst_pc", 32'(pc), 0);
    check("rst_phase", 32'(phase), 0);
    check("rst_state", 32'(state), 0);
    check("rst_retired", 32'(retired), 0);
    check("rst_wrap", 32'(pc_wrap), 0);

    // sequential run: commits on cycles 8, 16, 24
    n = 0;
    for (int cyc = 1; cyc <= 24; cyc++) begin
      step(1, 0, 0, 0, 0);
      if (obs_commit) begin
        if (n < 3) seen[n] = cyc;
        n++;
      end
    end
    check("seq_ncommit", 32'(n), 3);
    check("seq_c1", 32'(seen[0]), 8);
    check("seq_c2", 32'(seen[1]), 16);
    check("seq_c3", 32'(seen[2]), 24);
    #1;
    check("seq_pc", 32'(pc), 3);
    check("seq_retired", 32'(retired), 3);

    // branch held across commit, then a branch pulse away from commit
    for (int i = 0; i < 8; i++) step(1, 0, 0, 1, 16'h1234);
    #1;
    check("br_pc", 32'(pc), 32'h1234);
    check("br_wrap", 32'(pc_wrap), 0);
    for (int i = 0; i < 8; i++) step(1, 0, 0, (i == 3) ? 1 : 0, 16'h0BAD);
    #1;
    check("br_ignored_pc", 32'(pc), 32'h1235);

    // overflow on increment
    for (int i = 0; i < 8; i++) step(1, 0, 0, 1, 16'hFFFF);
    #1;
    check("wrap_pre_pc", 32'(pc), 32'hFFFF);
    check("wrap_pre_ret", 32'(retired), 6);
    for (int i = 0; i < 8; i++) step(1, 0, 0, 0, 0);
    #1;
    check("wrap_pc", 32'(pc), 0);
    check("wrap_pulse", 32'(pc_wrap), 1);
    check("wrap_ret", 32'(retired), 7);
    step(1, 0, 0, 0, 0);
    #1;
    check("wrap_one_cycle", 32'(pc_wrap), 0);
    for (int i = 0; i < 7; i++) step(1, 0, 0, 0, 0);

    // stall parked at the last phase: 4 stalled edges, then STALL->RUN, then commit
    for (int i = 0; i < 7; i++) step(1, 0, 0, 0, 0);
    #1;
    check("stall_ph7", 32'(phase), 7);
    for (int i = 0; i < 4; i++) begin
      step(1, 1, 0, 0, 0);
      check("stall_nocommit", 32'(obs_commit), 0);
    end
    #1;
    check("stall_state", 32'(state), 1);
    check("stall_phase", 32'(phase), 7);
    k = 0; found = 0;
    while (!found && k < 10) begin
      step(1, 0, 0, 0, 0);
      k++;
      found = obs_commit;
    end
    check("stall_len", 32'(7 + 4 + k), 13);

    // halt at commit with pc=5
    for (int i = 0; i < 8; i++) step(1, 0, 0, 1, 5);
    for (int i = 0; i < 8; i++) step(1, 0, (i == 7) ? 1 : 0, 0, 0);
    #1;
    check("halt_pc", 32'(pc), 5);
    check("halt_state", 32'(state), 2);
    check("halt_phase", 32'(phase), 0);
    check("halt_ret", 32'(retired), 11);
    n = 0;
    for (int i = 0; i < 50; i++) begin
      step(1, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 65535));
      if (obs_commit) n++;
    end
    check("halt_ncommit", 32'(n), 0);
    step(0, 0, 0, 0, 0);
    #1;
    check("halt_clr_pc", 32'(pc), 0);
    check("halt_clr_state", 32'(state), 0);
    check("halt_clr_ret", 32'(retired), 0);

    // reset mid-instruction
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0);
    #1;
    check("mid_phase4", 32'(phase), 4);
    step(0, 0, 0, 0, 0);
    #1;
    check("mid_phase", 32'(phase), 0);
    check("mid_pc", 32'(pc), 0);
    k = 0; found = 0;
    while (!found && k < 20) begin
      step(1, 0, 0, 0, 0);
      k++;
      found = obs_commit;
    end
    check("mid_first_commit", 32'(k), 8);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) == 0) ? 0 : 1,
           ($urandom_range(0, 5) == 0) ? 1 : 0,
           ($urandom_range(0, 29) == 0) ? 1 : 0,
           ($urandom_range(0, 3) == 0) ? 1 : 0,
           ($urandom_range(0, 2) == 0) ? 16'hFFFF : int'($urandom_range(0, 65535)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
